syncdowncnt: RTL and testbench

4-bit synchronous down counter with parallel load, count enable, one-shot or auto-reload mode, terminal-count pulse and a done/ack handshake. It runs in the opposite direction to the team's 4-bit synchronous up counter (`syncnt`) and keeps the same port style: `i` enable, `clk`, `rst`, and bit-level outputs `q0`..`q3`. It serves as a loadable timer or event down-counter: a controller loads a value, the block counts it out, and reports completion.

---
 rtl/syncdowncnt.sv | 108 ++++++++++
 tb/tb_syncdowncnt.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/syncdowncnt.sv
// 4-bit loadable down counter with one-shot / auto-reload modes, a registered
// terminal-count pulse and a done/ack completion handshake.
module syncdowncnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i,
    input  logic       ld,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       mode,
    input  logic       ack,
    output logic       q0,
    output logic       q1,
    output logic       q2,
    output logic       q3,
    output logic       tc,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] q, q_nx;
    logic [3:0] reload, reload_nx;
    logic       mode_r, mode_nx;
    logic       tc_r, tc_nx;
    logic [3:0] d;

    assign d = {d3, d2, d1, d0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q      <= 4'd0;
            reload <= 4'd0;
            mode_r <= 1'b0;
            tc_r   <= 1'b0;
        end else begin
            state  <= state_nx;
            q      <= q_nx;
            reload <= reload_nx;
            mode_r <= mode_nx;
            tc_r   <= tc_nx;
        end
    end

    // Handshake: done is held while in DONE and drops on the first edge that
    // samples ack=1; ack has no effect in any other state, and ld is ignored in DONE.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        reload_nx = reload;
        mode_nx   = mode_r;
        tc_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    q_nx      = d;
                    reload_nx = d;
                    mode_nx   = mode;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (ld) begin
                    q_nx      = d;
                    reload_nx = d;
                    mode_nx   = mode;
                end else if (i) begin
                    if (q > 4'd1) begin
                        q_nx = q - 4'd1;
                    end else if (q == 4'd1) begin
                        q_nx  = 4'd0;
                        tc_nx = 1'b1;
                        if (!mode_r) state_nx = DONE;
                    end else if (mode_r) begin
                        // A zero reload value keeps q at 0 and pulses tc every enabled edge.
                        q_nx  = reload;
                        tc_nx = (reload == 4'd0);
                    end else begin
                        tc_nx    = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                q_nx = 4'd0;
                if (ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign {q3, q2, q1, q0} = q;
    assign tc        = tc_r;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_syncdowncnt.sv
// Directed bench for syncdowncnt: a table of per-edge vectors plus hand-written
// reset and mid-run asynchronous reset sequences.
module tb_syncdowncnt;

    logic       clk;
    logic       rst;
    logic       i, ld, mode, ack;
    logic       d0, d1, d2, d3;
    logic       q0, q1, q2, q3;
    logic       tc, busy, done;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic       ld;
        logic [3:0] d;
        logic       mode;
        logic       i;
        logic       ack;
        logic [3:0] eq;
        logic       etc;
        logic       ebusy;
        logic       edone;
    } vec_t;

    vec_t tbl[$];

    syncdowncnt dut (
        .clk(clk), .rst(rst), .i(i), .ld(ld),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .mode(mode), .ack(ack),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .tc(tc), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic l, input logic [3:0] dv, input logic m,
                                input logic en, input logic a, input logic [3:0] eq,
                                input logic etc, input logic eb, input logic ed);
        vec_t v;
        v.ld = l; v.d = dv; v.mode = m; v.i = en; v.ack = a;
        v.eq = eq; v.etc = etc; v.ebusy = eb; v.edone = ed;
        return v;
    endfunction

    task automatic drive(input logic l, input logic [3:0] dv, input logic m,
                         input logic en, input logic a);
        ld = l; {d3, d2, d1, d0} = dv; mode = m; i = en; ack = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] exp_v);
        logic [6:0] act;
        act = {q3, q2, q1, q0, tc, busy, done};
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got q=%b tc=%b busy=%b done=%b, expected q=%b tc=%b busy=%b done=%b",
                     name, act[6:3], act[2], act[1], act[0],
                     exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] exp_s);
        n_cmp++;
        if (state_dbg !== exp_s) begin
            n_fail++;
            $display("FAIL %s: got state=%0d, expected state=%0d", name, state_dbg, exp_s);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        //              ld  d      mode  i     ack   q      tc    busy  done
        // one-shot 5
        tbl.push_back(mk(1, 4'd5,  0,    1,    0,    4'd5,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd4,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd3,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd2,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd1,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    0,    1));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  0,    0,    1));
        // ld together with ack in DONE: ld ignored, back to IDLE
        tbl.push_back(mk(1, 4'd7,  0,    1,    1,    4'd0,  0,    0,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  0,    0,    0));
        // auto-reload 3
        tbl.push_back(mk(1, 4'd3,  1,    1,    0,    4'd3,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd2,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd1,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd3,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd2,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd1,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    1,    0));
        // ack outside DONE has no effect; i=0 holds
        tbl.push_back(mk(0, 4'd0,  0,    0,    1,    4'd0,  0,    1,    0));
        // enable gating then load-beats-count
        tbl.push_back(mk(1, 4'd8,  0,    1,    0,    4'd8,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd7,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd6,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    0,    0,    4'd6,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    0,    0,    4'd6,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    0,    0,    4'd6,  0,    1,    0));
        tbl.push_back(mk(1, 4'd2,  0,    1,    0,    4'd2,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd1,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    0,    1));
        tbl.push_back(mk(0, 4'd0,  0,    0,    1,    4'd0,  0,    0,    0));
        // zero load, one-shot
        tbl.push_back(mk(1, 4'd0,  0,    1,    0,    4'd0,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    0,    1));
        tbl.push_back(mk(0, 4'd0,  0,    0,    1,    4'd0,  0,    0,    0));
        // zero load, auto-reload: tc held while i=1
        tbl.push_back(mk(1, 4'd0,  1,    1,    0,    4'd0,  0,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    1,    0,    4'd0,  1,    1,    0));
        tbl.push_back(mk(0, 4'd0,  0,    0,    0,    4'd0,  0,    1,    0));

        // Reset held from t=0, released between edges at 7.5
        #2;
        check("reset_before_edge", 7'b0000_000);
        check_state("reset_state", 2'd0);
        #4;
        check("reset_after_edge", 7'b0000_000);
        #1.5;
        rst = 1'b1;
        drive(1'b0, 4'd9, 1'b1, 1'b1, 1'b1);
        step();
        check("idle_ignores_i_1", 7'b0000_000);
        step();
        check("idle_ignores_i_2", 7'b0000_000);

        foreach (tbl[k]) begin
            drive(tbl[k].ld, tbl[k].d, tbl[k].mode, tbl[k].i, tbl[k].ack);
            step();
            check($sformatf("vec_%0d", k),
                  {tbl[k].eq, tbl[k].etc, tbl[k].ebusy, tbl[k].edone});
        end

        // Asynchronous reset in the middle of an auto-reload count from 15
        drive(1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
        step();
        check("mid_load_15", {4'd15, 1'b0, 1'b1, 1'b0});
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) step();
        check("mid_at_9", {4'd9, 1'b0, 1'b1, 1'b0});
        #3;
        rst = 1'b0;
        #1;
        check("mid_reset_immediate", 7'b0000_000);
        check_state("mid_reset_state", 2'd0);
        #7;
        rst = 1'b1;
        step();
        check("post_reset_ignore_i_1", 7'b0000_000);
        step();
        check("post_reset_ignore_i_2", 7'b0000_000);
        drive(1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
        step();
        check("post_reset_load", {4'd4, 1'b0, 1'b1, 1'b0});
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("post_reset_count", {4'd3, 1'b0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
